// File: rtl/dram_target_if.sv
// dram_target_if: Brew DRAM bus pins between a core (master) and one RAS-selected target (slave).
interface dram_target_if;
    logic [10:0] dram_addr;
    logic [7:0] dram_data_in;
    logic [7:0] dram_data_out;
    logic dram_data_out_en;
    logic dram_n_ras;
    logic dram_n_cas_0;
    logic dram_n_cas_1;
    logic dram_n_we;
    logic dram_n_wait;
    modport master (
        output dram_addr, dram_data_in, dram_n_ras, dram_n_cas_0, dram_n_cas_1, dram_n_we,
        input dram_data_out, dram_data_out_en, dram_n_wait
    );
    modport slave (
        input dram_addr, dram_data_in, dram_n_ras, dram_n_cas_0, dram_n_cas_1, dram_n_we,
        output dram_data_out, dram_data_out_en, dram_n_wait
    );
endinterface

// File: rtl/dram_target.sv
// dram_target: emulates one Brew DRAM bank in block RAM behind the multiplexed RAS/CAS bus.
// Define DRAM_TARGET_WAIT_EN to compile in the wait-state counter that drives dram_n_wait.
module dram_target #(
    parameter int MEM_ADDR_BITS = 12,
    parameter int WAIT_STATES = 2
) (
    input logic clk,
    input logic rst,
    dram_target_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ROW = 2'd1, WAIT = 2'd2, ACCESS = 2'd3;
`ifdef DRAM_TARGET_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam logic [1:0] AFTER_ROW = WAIT_EN && WAIT_STATES > 0 ? WAIT : ACCESS;

    logic [10:0] s_addr, row;
    logic [7:0] s_data_in;
    logic s_n_ras, p_n_ras, s_n_cas_0, s_n_cas_1, s_n_we;
    logic [1:0] state, nxt;
    logic wr, cas_any, ras_fall, detect, is_wr;
    logic [MEM_ADDR_BITS-1:0] wa;
    logic [15:0] mem [2**MEM_ADDR_BITS];
`ifdef DRAM_TARGET_WAIT_EN
    logic [3:0] cnt;
`endif

    assign cas_any = ~s_n_cas_0 | ~s_n_cas_1;
    assign ras_fall = p_n_ras & ~s_n_ras;
    assign detect = state == ROW && !s_n_ras && cas_any;
    assign is_wr = detect ? ~s_n_we : wr;
    // Column supplies the LSBs; row bits above the memory size alias away.
    assign wa = MEM_ADDR_BITS'({row, s_addr});

    always_comb begin
        nxt = state;
        if (state != IDLE && s_n_ras) nxt = IDLE;
        else if (state == IDLE) nxt = ras_fall ? ROW : IDLE;
        else if (detect) nxt = AFTER_ROW;
`ifdef DRAM_TARGET_WAIT_EN
        else if (state == WAIT) nxt = cnt == 4'd0 ? ACCESS : WAIT;
`endif
        else if (state == ACCESS && !cas_any) nxt = ROW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s_addr <= '0;
            s_data_in <= '0;
            s_n_ras <= 1'b1;
            p_n_ras <= 1'b1;
            s_n_cas_0 <= 1'b1;
            s_n_cas_1 <= 1'b1;
            s_n_we <= 1'b1;
            row <= '0;
            wr <= 1'b0;
            bus.dram_data_out <= 8'h00;
            bus.dram_data_out_en <= 1'b0;
        end else begin
            s_addr <= bus.dram_addr;
            s_data_in <= bus.dram_data_in;
            s_n_ras <= bus.dram_n_ras;
            p_n_ras <= s_n_ras;
            s_n_cas_0 <= bus.dram_n_cas_0;
            s_n_cas_1 <= bus.dram_n_cas_1;
            s_n_we <= bus.dram_n_we;
            state <= nxt;
            if (state == IDLE && ras_fall) row <= s_addr;
            if (detect) wr <= ~s_n_we;
            if (detect && s_n_we) bus.dram_data_out <= !s_n_cas_0 ? mem[wa][7:0] : mem[wa][15:8];
            bus.dram_data_out_en <= nxt == ACCESS && cas_any && !is_wr;
        end
    end

    // Byte-enable write; a write colliding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && detect && !s_n_we) begin
            if (!s_n_cas_0) mem[wa][7:0] <= s_data_in;
            if (!s_n_cas_1) mem[wa][15:8] <= s_data_in;
        end
    end

`ifdef DRAM_TARGET_WAIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
            bus.dram_n_wait <= 1'b1;
        end else begin
            cnt <= detect ? 4'(WAIT_STATES - 1) : state == WAIT && cnt != 4'd0 ? cnt - 4'd1 : cnt;
            bus.dram_n_wait <= nxt != WAIT;
        end
    end
`else
    assign bus.dram_n_wait = 1'b1;
`endif
endmodule

// File: tb/tb_dram_target.sv
// tb_dram_target: directed checks of dram_target; wait-state expectations follow DRAM_TARGET_WAIT_EN.
module tb_dram_target;
`ifdef DRAM_TARGET_WAIT_EN
    localparam int WS = 2;
    localparam int L = 2;
`else
    localparam int WS = 5;
    localparam int L = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    dram_target_if bus();

    dram_target #(.MEM_ADDR_BITS(12), .WAIT_STATES(WS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.dram_n_ras = 1'b1;
        bus.dram_n_cas_0 = 1'b1;
        bus.dram_n_cas_1 = 1'b1;
        bus.dram_n_we = 1'b1;
    endtask

    task automatic ras_open(input logic [10:0] r);
        bus.dram_addr = r;
        bus.dram_n_ras = 1'b0;
        step(2);
    endtask

    task automatic ras_close();
        bus_idle();
        step(2);
    endtask

    task automatic cas_release();
        bus.dram_n_cas_0 = 1'b1;
        bus.dram_n_cas_1 = 1'b1;
        bus.dram_n_we = 1'b1;
        step(2);
    endtask

    task automatic write(input logic [10:0] c, input logic [1:0] lanes, input logic [7:0] d);
        bus.dram_addr = c;
        bus.dram_data_in = d;
        bus.dram_n_cas_0 = ~lanes[0];
        bus.dram_n_cas_1 = ~lanes[1];
        bus.dram_n_we = 1'b0;
        step(2 + L);
        check("wr_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        cas_release();
    endtask

    task automatic read(input logic [10:0] c, input logic [1:0] lanes, input logic [7:0] exp, input string tag);
        bus.dram_addr = c;
        bus.dram_n_cas_0 = ~lanes[0];
        bus.dram_n_cas_1 = ~lanes[1];
        bus.dram_n_we = 1'b1;
        step(2);
        for (int i = 0; i < L; i++) begin
            check({tag, "_wait_lo"}, {7'd0, bus.dram_n_wait}, 8'd0);
            check({tag, "_en_early"}, {7'd0, bus.dram_data_out_en}, 8'd0);
            step(1);
        end
        check({tag, "_en"}, {7'd0, bus.dram_data_out_en}, 8'd1);
        check({tag, "_data"}, bus.dram_data_out, exp);
        check({tag, "_wait_hi"}, {7'd0, bus.dram_n_wait}, 8'd1);
        cas_release();
        check({tag, "_en_off"}, {7'd0, bus.dram_data_out_en}, 8'd0);
    endtask

    initial begin
        bus_idle();
        bus.dram_addr = '0;
        bus.dram_data_in = '0;
        step(3);
        check("rst_wait", {7'd0, bus.dram_n_wait}, 8'd1);
        check("rst_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        check("rst_data", bus.dram_data_out, 8'h00);
        rst = 1'b0;
        step(3);
        check("idle_wait", {7'd0, bus.dram_n_wait}, 8'd1);
        check("idle_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        check("idle_data", bus.dram_data_out, 8'h00);

        ras_open(11'h001);
        write(11'h005, 2'b01, 8'hA5);
        ras_close();
        ras_open(11'h001);
        read(11'h005, 2'b01, 8'hA5, "rw");
        ras_close();

        ras_open(11'h000);
        write(11'h007, 2'b01, 8'h12);
        write(11'h007, 2'b10, 8'h34);
        write(11'h008, 2'b11, 8'h5A);
        write(11'h009, 2'b01, 8'h77);
        read(11'h007, 2'b01, 8'h12, "lane0");
        read(11'h007, 2'b10, 8'h34, "lane1");
        read(11'h008, 2'b10, 8'h5A, "both_hi");
        read(11'h008, 2'b01, 8'h5A, "both_lo");
        for (int i = 0; i < 4; i++) write(11'(i), 2'b01, 8'h10 + 8'(i));
        ras_close();

        ras_open(11'h002);
        for (int i = 0; i < 4; i++) read(11'(i), 2'b01, 8'h10 + 8'(i), "page");
        ras_close();

        ras_open(11'h001);
        bus.dram_addr = 11'h005;
        bus.dram_n_cas_0 = 1'b0;
        bus.dram_n_we = 1'b1;
        step(2);
        if (L > 0) check("abort_wait_lo", {7'd0, bus.dram_n_wait}, 8'd0);
        bus.dram_n_ras = 1'b1;
        step(2);
        check("abort_wait", {7'd0, bus.dram_n_wait}, 8'd1);
        check("abort_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        step(L + 3);
        check("idle_cas_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        check("idle_cas_wait", {7'd0, bus.dram_n_wait}, 8'd1);
        cas_release();
        ras_open(11'h001);
        read(11'h005, 2'b01, 8'hA5, "after_abort");
        ras_close();

        ras_open(11'h000);
        bus.dram_addr = 11'h009;
        bus.dram_data_in = 8'hEE;
        bus.dram_n_cas_0 = 1'b0;
        bus.dram_n_we = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        check("rst_mid_data", bus.dram_data_out, 8'h00);
        check("rst_mid_en", {7'd0, bus.dram_data_out_en}, 8'd0);
        rst = 1'b0;
        bus_idle();
        step(3);
        ras_open(11'h000);
        read(11'h009, 2'b01, 8'h77, "rst_discard");
        ras_close();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
